// File: rtl/apb_master_nslv.sv
// rtl/apb_master_nslv.sv - parametrised APB master bridge with one-hot slave decode
// Accepts single commands, runs SETUP/ENABLE on the decoded slave and returns one response each.
module apb_master_nslv #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int SLV_ADDR_WIDTH = 2,
   parameter int NUM_SLAVES     = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             pclk,
   input  logic                             preset,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [DATA_WIDTH-1:0]            cmd_wdata,
   output logic                             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [2:0]                       rsp_err,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [DATA_WIDTH-1:0]            pwdata,
   output logic                             pwrite,
   output logic                             penable,
   output logic [NUM_SLAVES-1:0]            psel,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   localparam int IW = ADDR_WIDTH - SLV_ADDR_WIDTH;
   // A zero timeout still needs a one-bit counter to keep the logic legal.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ENABLE = 2'd2;

   logic [1:0]            state;
   logic [IW-1:0]         idx_q;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  write_q;

   logic [IW-1:0]         cmd_idx;
   logic                  accept;
   logic                  addr_bad;
   logic                  tmo_hit;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_rdata;

   assign cmd_idx  = cmd_addr[ADDR_WIDTH-1:SLV_ADDR_WIDTH];
   assign accept   = cmd_valid && cmd_ready;
   assign addr_bad = 32'(cmd_idx) >= NUM_SLAVES;
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && ((32'(cnt) + 32'd1) == TIMEOUT_CYCLES);

   assign cmd_ready = (state == ST_IDLE);
   assign penable   = (state == ST_ENABLE);
   assign paddr     = addr_q;
   assign pwdata    = wdata_q;
   assign pwrite    = write_q;

   // Only the selected slave's handshake is visible; everything else is ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      psel      = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IW'(i)) begin
            sel_ready = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
            psel[i]   = (state != ST_IDLE);
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= ST_IDLE;
         idx_q     <= '0;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 3'b000;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  write_q <= cmd_write;
                  idx_q   <= cmd_idx;
                  cnt     <= '0;
                  if (addr_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 3'b001;
                     rsp_rdata <= '0;
                  end else begin
                     state <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: state <= ST_ENABLE;
            ST_ENABLE: begin
               // Completion takes priority over a timeout landing in the same cycle.
               if (sel_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= {sel_err, 2'b00};
                  rsp_rdata <= (!write_q && !sel_err) ? sel_rdata : '0;
               end else if (tmo_hit) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 3'b010;
                  rsp_rdata <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
